// File: rtl/multi_edge_dect.sv
// -----------------------------------------------------------------------------
// multi_edge_dect
//
// Multi-channel edge detector for asynchronous GPIO/status inputs. Each
// channel has:
//   - a SYNC_STAGES-deep synchroniser,
//   - an optional glitch filter (compiled in with MULTI_EDGE_DECT_FILT_EN),
//   - a per-channel detect mode (off / rising / falling / both),
//   - a registered one-cycle event pulse and a sticky event flag with clear.
// All sticky flags are ORed into a single interrupt line.
//
// Build option:
//   MULTI_EDGE_DECT_FILT_EN defined   : a per-channel glitch filter is built.
//                                       A new input level must persist for
//                                       filt_len+1 consecutive cycles before
//                                       it is accepted.
//   MULTI_EDGE_DECT_FILT_EN undefined : no filter. Every synchronised change
//                                       is accepted one cycle later, and
//                                       filt_len is ignored.
//
// Ports:
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   sig_in     in   CH       raw asynchronous channel inputs
//   mode       in   2*CH     per-channel mode [2i+1:2i]: 00 off, 01 rise,
//                            10 fall, 11 both
//   filt_len   in   FILT_W   glitch-filter length (extra cycles required)
//   evt_clr    in   CH       per-channel sticky-flag clear (level)
//   evt_pulse  out  CH       one-cycle pulse per accepted, enabled edge
//   evt_flag   out  CH       sticky event flags
//   irq        out  1        OR of all evt_flag bits
// -----------------------------------------------------------------------------
module multi_edge_dect #(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       sig_in,
    input  logic [2*CH-1:0]     mode,
    input  logic [FILT_W-1:0]   filt_len,
    input  logic [CH-1:0]       evt_clr,
    output logic [CH-1:0]       evt_pulse,
    output logic [CH-1:0]       evt_flag,
    output logic                irq
);

    // ------------------------------------------------------------------
    // Synchroniser: a pure flop chain, no logic between the stages.
    // ------------------------------------------------------------------
    logic [CH-1:0] sync_q [SYNC_STAGES];
    logic [CH-1:0] s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= sig_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-channel acceptance: accept[i] is high in the cycle where
    // stable[i] will take the value of s[i] on the next edge.
    // ------------------------------------------------------------------
    logic [CH-1:0] stable_q;
    logic [CH-1:0] accept;
    logic [CH-1:0] pulse_next;

`ifdef MULTI_EDGE_DECT_FILT_EN
    for (genvar i = 0; i < CH; i++) begin : g_filt
        logic [FILT_W-1:0] cnt_q;
        logic              differs;

        assign differs   = s[i] ^ stable_q[i];
        assign accept[i] = differs && (cnt_q == filt_len);

        // The counter restarts whenever s falls back to stable, and is
        // free to wrap if filt_len is lowered below its current value;
        // it then counts up through zero until it meets filt_len again.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (!differs) begin
                cnt_q <= '0;
            end else if (cnt_q == filt_len) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + FILT_W'(1);
            end
        end
    end
`else
    // No filter: filt_len is kept on the port for a uniform interface.
    logic unused_filt_len;
    assign unused_filt_len = ^filt_len;

    assign accept = s ^ stable_q;
`endif

    // ------------------------------------------------------------------
    // Stable level tracking and edge decode. Tracking runs regardless of
    // mode, so a mode change never creates an edge on its own.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CH; i++) begin : g_edge
        logic rise;
        logic fall;

        assign rise          = accept[i] &  s[i];
        assign fall          = accept[i] & ~s[i];
        assign pulse_next[i] = (rise & mode[2*i]) | (fall & mode[2*i+1]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stable_q[i] <= 1'b0;
            end else if (accept[i]) begin
                stable_q[i] <= s[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Event outputs. A new event in the same cycle as a clear wins, so
    // an event can never be lost to a held or colliding clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_pulse <= '0;
            evt_flag  <= '0;
        end else begin
            evt_pulse <= pulse_next;
            evt_flag  <= pulse_next | (evt_flag & ~evt_clr);
        end
    end

    assign irq = |evt_flag;

endmodule

// File: tb/tb_multi_edge_dect.sv
module tb_multi_edge_dect;

    logic        clk;
    logic        rst;
    logic [7:0]  sig_in;
    logic [15:0] mode;
    logic [3:0]  filt_len;
    logic [7:0]  evt_clr;
    logic [7:0]  evt_pulse;
    logic [7:0]  evt_flag;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] acc;
    logic [7:0] acc2;

    multi_edge_dect #(
        .CH          (8),
        .SYNC_STAGES (2),
        .FILT_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .mode      (mode),
        .filt_len  (filt_len),
        .evt_clr   (evt_clr),
        .evt_pulse (evt_pulse),
        .evt_flag  (evt_flag),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // OR of evt_pulse over the next n cycles
    task automatic watch(input int n, output logic [7:0] a);
        a = 8'h00;
        repeat (n) begin
            @(negedge clk);
            a |= evt_pulse;
        end
    endtask

    initial begin
        rst = 1'b1; sig_in = 8'h00; mode = 16'h0000; filt_len = 4'd0; evt_clr = 8'h00;
        step(2);
        chk("reset_pulse", evt_pulse, 8'h00);
        chk("reset_flag",  evt_flag,  8'h00);
        chk("reset_irq",   {7'b0, irq}, 8'h00);
        rst = 1'b0;
        watch(20, acc);
        chk("idle_pulses", acc, 8'h00);
        chk("idle_irq", {7'b0, irq}, 8'h00);

        // rising only on channel 0
        mode = 16'h0001; sig_in = 8'h01;
        step(2); chk("rise_early", evt_pulse, 8'h00);
        step(1); chk("rise_pulse", evt_pulse, 8'h01);
        chk("rise_flag", evt_flag, 8'h01);
        chk("rise_irq", {7'b0, irq}, 8'h01);
        step(1); chk("rise_one_cycle", evt_pulse, 8'h00);
        step(3); sig_in = 8'h00;
        watch(10, acc);
        chk("rise_no_fall_evt", acc, 8'h00);
        chk("rise_flag_sticky", evt_flag, 8'h01);
        evt_clr = 8'h01; step(1); evt_clr = 8'h00;
        chk("clr_flag", evt_flag, 8'h00);
        chk("clr_irq", {7'b0, irq}, 8'h00);

        // both edges, all channels
        mode = 16'hFFFF; sig_in = 8'hFF;
        step(2); chk("all_rise_early", evt_pulse, 8'h00);
        step(1); chk("all_rise", evt_pulse, 8'hFF);
        step(1); chk("all_rise_end", evt_pulse, 8'h00);
        step(6); sig_in = 8'h00;
        step(2); chk("all_fall_early", evt_pulse, 8'h00);
        step(1); chk("all_fall", evt_pulse, 8'hFF);
        step(1); chk("all_fall_end", evt_pulse, 8'h00);
        watch(10, acc);
        chk("all_quiet", acc, 8'h00);
        chk("all_flags", evt_flag, 8'hFF);
        chk("all_irq", {7'b0, irq}, 8'h01);
        evt_clr = 8'hFF; step(1); evt_clr = 8'h00;
        chk("all_clr", evt_flag, 8'h00);

        // clear/set collision on channel 1
        sig_in = 8'h02;
        step(3); chk("coll_setup_pulse", evt_pulse, 8'h02);
        chk("coll_setup_flag", evt_flag, 8'h02);
        sig_in = 8'h00;
        step(2); evt_clr = 8'h02;
        step(1); chk("coll_pulse", evt_pulse, 8'h02);
        chk("coll_set_wins", evt_flag, 8'h02);
        step(1); chk("coll_clear_after", evt_flag, 8'h00);
        chk("coll_irq_low", {7'b0, irq}, 8'h00);
        sig_in = 8'h02;
        step(3); chk("set_under_held_clr", evt_flag, 8'h02);
        step(1); chk("held_clr_drops", evt_flag, 8'h00);
        evt_clr = 8'h00; sig_in = 8'h00;
        step(5); evt_clr = 8'hFF; step(1); evt_clr = 8'h00;
        chk("coll_cleanup", evt_flag, 8'h00);

        // mode off on channel 3, then enable rising with input held high
        mode = 16'h0000;
        acc2 = 8'h00;
        for (int k = 0; k < 5; k++) begin
            sig_in[3] = ~sig_in[3];
            watch(4, acc);
            acc2 |= acc;
        end
        chk("off_pulses", acc2, 8'h00);
        chk("off_flag", evt_flag, 8'h00);
        mode = 16'h0040;
        watch(10, acc); chk("mode_change_nopulse", acc, 8'h00);
        sig_in[3] = 1'b0;
        watch(6, acc); chk("ch3_fall_ignored", acc, 8'h00);
        sig_in[3] = 1'b1;
        step(3); chk("ch3_rise", evt_pulse, 8'h08);
        evt_clr = 8'hFF; step(1); evt_clr = 8'h00;

        // mixed modes: even channels rising, odd channels falling
        mode = 16'h9999; sig_in = 8'h0F;
        step(3); chk("mixed_rise", evt_pulse, 8'h05);
        sig_in = 8'h00;
        step(3); chk("mixed_fall", evt_pulse, 8'h0A);
        chk("mixed_flags", evt_flag, 8'h0F);

        // asynchronous reset mid-operation, pulse and flags active
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pulse", evt_pulse, 8'h00);
        chk("async_rst_flag",  evt_flag,  8'h00);
        chk("async_rst_irq",   {7'b0, irq}, 8'h00);

        // input high at reset release gives one rising event
        sig_in = 8'h10; mode = 16'h0100;
        step(2); rst = 1'b0;
        step(2); chk("post_rst_early", evt_pulse, 8'h00);
        step(1); chk("post_rst_rise", evt_pulse, 8'h10);
        step(1); chk("post_rst_once", evt_pulse, 8'h00);

        sig_in = 8'h00; mode = 16'h0030;
        step(6); evt_clr = 8'hFF; step(1); evt_clr = 8'h00;

`ifdef MULTI_EDGE_DECT_FILT_EN
        filt_len = 4'd3;
        sig_in = 8'h04; step(3); sig_in = 8'h00;
        watch(12, acc); chk("filt_short_dropped", acc, 8'h00);
        sig_in = 8'h04; step(4); sig_in = 8'h00;
        step(1); chk("filt_rise_early", evt_pulse, 8'h00);
        step(1); chk("filt_rise", evt_pulse, 8'h04);
        step(3); chk("filt_fall_early", evt_pulse, 8'h00);
        step(1); chk("filt_fall", evt_pulse, 8'h04);
`else
        filt_len = 4'd3;
        sig_in = 8'h04; step(1); sig_in = 8'h00;
        step(1); chk("glitch_early", evt_pulse, 8'h00);
        step(1); chk("glitch_rise", evt_pulse, 8'h04);
        step(1); chk("glitch_fall", evt_pulse, 8'h04);
        step(1); chk("glitch_end", evt_pulse, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_edge_dect.md
Name: multi_edge_dect

Overview:
- Multi-channel edge detector that extends the single-channel edge detector to CH inputs.
- Each channel has a configurable detect mode (off / rising / falling / both) and an input synchroniser.
- Each channel has an optional programmable glitch filter and a sticky event flag with clear.
- Sits between asynchronous GPIO/status inputs and the interrupt/control logic; drives one aggregated interrupt line.

Parameters:
- CH, 8, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- FILT_W, 4, width of the glitch-filter length and counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- sig_in  input  CH  raw asynchronous channel inputs
- mode  input  2*CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- filt_len  input  FILT_W  common filter length, in cycles beyond the minimum
- evt_clr  input  CH  per-channel sticky-flag clear, level-sampled
- evt_pulse  output  CH  one-cycle pulse per detected edge
- evt_flag  output  CH  sticky event flags
- irq  output  1  OR of all evt_flag bits

Behaviour:
- Reset (rst=1, asynchronous): all registers are cleared. This includes the synchroniser flops, stable[CH], filter counters, evt_pulse and evt_flag. irq=0.
- Synchroniser:
  - sig_in[i] passes through SYNC_STAGES flops; s[i] is the last stage.
  - No logic may sit between the synchroniser stages.
- Glitch filter, per channel, counter cnt[i] of FILT_W bits:
  - If s==stable and cnt!=0: cnt<=0.
  - If s!=stable and cnt==filt_len: stable<=s, cnt<=0 (the edge is accepted).
  - If s!=stable and cnt!=filt_len: cnt<=cnt+1.
  - s must differ from stable for filt_len+1 consecutive cycles before it is accepted. A pulse shorter than that is dropped, and the counter restarts whenever s returns to stable.
  - filt_len=0: stable follows s one cycle later.
  - filt_len is sampled every cycle. If filt_len is lowered below the current cnt, the next compare cannot match until the counter wraps. The counter is allowed to wrap modulo 2^FILT_W; it must not lock up.
- Edge detection:
  - evt_pulse[i] is registered and asserts on the same clock edge that stable[i] updates.
  - It asserts for rising (0->1) when mode[i] is 01 or 11.
  - It asserts for falling (1->0) when mode[i] is 10 or 11.
  - It deasserts the next cycle unless another accepted edge occurs.
  - Mode 00 suppresses pulses, but the filter and stable tracking keep running.
  - A mode change takes effect on the next accepted edge. A mode change by itself never generates a pulse.
- Latency: a sig_in transition held stable produces evt_pulse exactly SYNC_STAGES+filt_len+1 clock edges after the first edge that samples it. Defaults with filt_len=0: 3 cycles.
- Post-reset: stable=0, so an input that is high at reset release yields one rising event after the latency above. Verification expects this; it is not suppressed.
- Sticky flags:
  - evt_flag[i] <= evt_pulse_next[i] | (evt_flag[i] & ~evt_clr[i]).
  - When a set and a clear occur in the same cycle, the set wins and the flag stays 1.
  - Holding evt_clr does not block future sets.
- irq = |evt_flag, combinational from registered flags.
- Channels are fully independent; simultaneous edges on any set of channels are all reported in the same cycle.

Optional Feature:
- Macro: MULTI_EDGE_DECT_FILT_EN
- Defined: the glitch filter is implemented as described above.
- Undefined:
  - No filter counters are generated and filt_len is ignored (the port is kept, unused).
  - stable[i] <= s[i] every cycle.
  - Latency is SYNC_STAGES+1 cycles; a single-cycle glitch that survives synchronisation produces two events.
- All other behaviour is identical in both builds.

Test Plan:
- Reset and idle:
  - Stimulus: rst=1 mid-operation with flags set, then release with sig_in=0.
  - Response: all outputs 0 immediately on reset assertion; no pulses for 20 cycles after release.
- Rising only:
  - Stimulus: CH=8, mode[0]=01, filt_len=0; sig_in[0] goes 0->1, holds, then 1->0.
  - Response: exactly one evt_pulse[0] 3 cycles after the rise, none on the fall; evt_flag[0]=1, irq=1.
- Both edges, all channels:
  - Stimulus: mode=all 11; toggle sig_in=8'hFF, then back to 8'h00 10 cycles later.
  - Response: evt_pulse=8'hFF for one cycle, twice; no other pulses.
- Glitch filter (FILT_EN build):
  - Stimulus: filt_len=3; 3-cycle high pulse on sig_in[2], then a 4-cycle high pulse.
  - Response: no event for the 3-cycle pulse. The 4-cycle pulse gives its rise event at latency 2+3+1=6 cycles and its fall event 4 cycles after that.
- Clear vs set collision:
  - Stimulus: evt_flag[1]=1; assert evt_clr[1] in the same cycle a new edge is accepted on channel 1.
  - Response: evt_flag[1] stays 1. Clearing with no event drops it to 0 and irq follows.
- Mode off:
  - Stimulus: mode[3]=00; toggle sig_in[3] 5 times; then set mode[3]=01 with the input held high.
  - Response: no pulses in either phase; the next 0->1 on sig_in[3] produces a pulse.
